// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared constants and types for the EX-stage multiply/divide
//                unit: operation encodings, FSM state type, datapath width.
//  Revision    : 1.0  - initial release
// ============================================================================
package mips_pkg;

    localparam int WIDTH = 32;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } md_state_t;

    // Signed operations are the ones with op[0] clear (MULT, DIV)
    function automatic logic md_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    // Divide operations are the ones with op[1] set (DIV, DIVU)
    function automatic logic md_is_div(input logic [1:0] op);
        return op[1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_datapath
//  Description : Iterative shift-add multiplier / restoring divider working on
//                operand magnitudes, with the final sign correction applied
//                combinationally on the outputs.
//  Revision    : 1.0  - initial release
// ============================================================================
module muldiv_datapath
    import mips_pkg::*;
#(
    parameter int WIDTH = mips_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_step,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    // Captured operation context
    logic             r_is_div;
    logic             r_neg_res;
    logic             r_neg_rem;
    logic             r_div0;
    logic [WIDTH-1:0] r_a_raw;
    logic [WIDTH-1:0] r_b;
    // r_acc: upper product half / partial remainder; r_q: multiplier / quotient
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_q;

    logic             w_signed;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH-1:0] w_acc_nxt;
    logic [WIDTH-1:0] w_q_nxt;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0] w_quo_fix;
    logic [WIDTH-1:0] w_rem_fix;

    assign w_signed = md_is_signed(i_op);
    assign w_a_neg  = w_signed & i_a[WIDTH-1];
    assign w_b_neg  = w_signed & i_b[WIDTH-1];
    assign w_a_mag  = w_a_neg ? -i_a : i_a;
    assign w_b_mag  = w_b_neg ? -i_b : i_b;

    // One iteration of either algorithm, selected by the captured op
    always_comb begin
        w_sum     = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
        w_shift   = {r_acc, r_q[WIDTH-1]};
        w_trial   = w_shift - {1'b0, r_b};
        w_acc_nxt = r_acc;
        w_q_nxt   = r_q;
        if (r_is_div) begin
            // Restoring step: keep the trial difference only when it is non-negative.
            // The remainder stays below the divisor, so it always fits in WIDTH bits.
            if (!w_trial[WIDTH]) begin
                w_acc_nxt = w_trial[WIDTH-1:0];
                w_q_nxt   = {r_q[WIDTH-2:0], 1'b1};
            end else begin
                w_acc_nxt = w_shift[WIDTH-1:0];
                w_q_nxt   = {r_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            // Shift-add step: the product shifts right through {r_acc, r_q}
            w_acc_nxt = w_sum[WIDTH:1];
            w_q_nxt   = {w_sum[0], r_q[WIDTH-1:1]};
        end
    end

    // Operand capture on start, then one iteration per step cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_div0    <= 1'b0;
            r_a_raw   <= '0;
            r_b       <= '0;
            r_acc     <= '0;
            r_q       <= '0;
        end else if (i_load) begin
            r_is_div  <= md_is_div(i_op);
            r_neg_res <= w_a_neg ^ w_b_neg;
            r_neg_rem <= w_a_neg;
            r_div0    <= md_is_div(i_op) & (i_b == '0);
            r_a_raw   <= i_a;
            r_b       <= w_b_mag;
            r_acc     <= '0;
            r_q       <= w_a_mag;
        end else if (i_step) begin
            r_acc     <= w_acc_nxt;
            r_q       <= w_q_nxt;
        end
    end

    // Sign correction and result selection; divide-by-zero returns the raw
    // dividend in HI and all ones in LO regardless of operand signs
    always_comb begin
        w_prod     = {r_acc, r_q};
        w_prod_fix = r_neg_res ? -w_prod : w_prod;
        w_quo_fix  = r_neg_res ? -r_q : r_q;
        w_rem_fix  = r_neg_rem ? -r_acc : r_acc;
        if (r_is_div && r_div0) begin
            o_hi = r_a_raw;
            o_lo = '1;
        end else if (r_is_div) begin
            o_hi = w_rem_fix;
            o_lo = w_quo_fix;
        end else begin
            o_hi = w_prod_fix[2*WIDTH-1:WIDTH];
            o_lo = w_prod_fix[WIDTH-1:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : ex_muldiv_unit
//  Description : EX-stage iterative multiply/divide unit. Owns HI/LO, runs
//                MULT/MULTU/DIV/DIVU over ITER cycles and requests a pipeline
//                stall for any HI/LO access or new mul/div while busy.
//  Revision    : 1.0  - initial release
// ============================================================================
module ex_muldiv_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = mips_pkg::WIDTH,
    parameter int ITER  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] alu_A,
    input  logic [WIDTH-1:0] alu_B,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic             mfhi,
    input  logic             mflo,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall_req
);

    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

    md_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_done;

    logic             w_load;
    logic             w_step;
    logic [WIDTH-1:0] w_dp_hi;
    logic [WIDTH-1:0] w_dp_lo;

    assign w_load = (r_state == ST_IDLE) & start;
    assign w_step = (r_state == ST_RUN);

    muldiv_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk    (clk),
        .rst    (reset),
        .i_load (w_load),
        .i_step (w_step),
        .i_op   (op),
        .i_a    (alu_A),
        .i_b    (alu_B),
        .o_hi   (w_dp_hi),
        .o_lo   (w_dp_lo)
    );

    // Control FSM plus the architectural HI/LO registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // A start takes priority over a simultaneous move
                    if (start) begin
                        r_cnt   <= '0;
                        r_state <= ST_RUN;
                    end else begin
                        if (mthi) r_hi <= alu_A;
                        if (mtlo) r_lo <= alu_A;
                    end
                end
                ST_RUN: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(ITER - 1)) r_state <= ST_FIX;
                end
                ST_FIX: begin
                    r_hi    <= w_dp_hi;
                    r_lo    <= w_dp_lo;
                    r_done  <= 1'b1;
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign hi        = r_hi;
    assign lo        = r_lo;
    assign done      = r_done;
    assign busy      = (r_state != ST_IDLE);
    assign stall_req = busy & (start | mfhi | mflo | mthi | mtlo);

endmodule
`default_nettype wire
